// File: rtl/eth_l3_pkg.sv
// eth_l3_pkg
// Shared definitions for the receive-side IPv4 header verdict stage:
// FSM state encoding, HdrErr bit positions and the IPv4 constants the
// verdict is judged against.
package eth_l3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ETYPE   = 3'd1,
    ST_HDR     = 3'd2,
    ST_WAIT_CS = 3'd3,
    ST_PRESENT = 3'd4
  } state_t;

  // Bit positions inside HdrErr
  localparam int ERR_NOT_IP      = 0;
  localparam int ERR_BAD_VER_IHL = 1;
  localparam int ERR_BAD_CSUM    = 2;
  localparam int ERR_BAD_LEN     = 3;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
  localparam logic [15:0] IPV4_HDR_LEN = 16'd20;

endpackage

// File: rtl/eth_l3_field_cap.sv
// eth_l3_field_cap
// Offset-decoded capture registers for the IPv4 header fields that are
// forwarded with the verdict.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : zero all fields (start of a new frame)
//   capture     : current byte belongs to the IPv4 header
//   offset      : byte offset inside the IPv4 header
//   data        : current RX byte
//   protocol    : header offset 9
//   total_len   : header offsets 2..3, big-endian
//   dst_ip      : header offsets 16..19, first wire byte in the MSBs
module eth_l3_field_cap
  import eth_l3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        capture,
  input  logic [15:0] offset,
  input  logic [7:0]  data,
  output logic [7:0]  protocol,
  output logic [15:0] total_len,
  output logic [31:0] dst_ip
);

  // Clear wins over capture so that a frame restart never leaks a byte
  // of the aborted frame into the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol  <= '0;
      total_len <= '0;
      dst_ip    <= '0;
    end else if (clear) begin
      protocol  <= '0;
      total_len <= '0;
      dst_ip    <= '0;
    end else if (capture) begin
      case (offset)
        16'd2:   total_len[15:8] <= data;
        16'd3:   total_len[7:0]  <= data;
        16'd9:   protocol        <= data;
        16'd16:  dst_ip[31:24]   <= data;
        16'd17:  dst_ip[23:16]   <= data;
        16'd18:  dst_ip[15:8]    <= data;
        16'd19:  dst_ip[7:0]     <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/eth_l3_hdr_check.sv
// eth_l3_hdr_check
// Receive-side IPv4 header verdict stage. Parses EtherType and the IPv4
// header from the RX byte stream, merges the checksum unit's result and
// presents one verdict per frame over a valid/ready handshake.
// Ports:
//   MRxClk, Reset_n      : clock, asynchronous active-low reset
//   RxData/RxValid       : RX byte stream
//   ByteCnt              : frame byte index of RxData
//   RxStartFrm/RxEndFrm  : first / last byte markers
//   CheckSum/CSready     : checksum unit result (level valid)
//   HdrValid/HdrReady    : verdict handshake
//   HdrErr/HdrOk         : error bits and their all-clear summary
//   Protocol/TotalLen/DstIp : captured IPv4 fields
//   Overrun              : pulse when a frame starts while a verdict waits
module eth_l3_hdr_check
  import eth_l3_pkg::*;
#(
  parameter logic [15:0] HDR_BASE   = 16'h17,
  parameter int          CS_TIMEOUT = 8
) (
  input  logic        MRxClk,
  input  logic        Reset_n,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  input  logic [15:0] ByteCnt,
  input  logic        RxStartFrm,
  input  logic        RxEndFrm,
  input  logic [15:0] CheckSum,
  input  logic        CSready,
  output logic        HdrValid,
  input  logic        HdrReady,
  output logic [3:0]  HdrErr,
  output logic        HdrOk,
  output logic [7:0]  Protocol,
  output logic [15:0] TotalLen,
  output logic [31:0] DstIp,
  output logic        Overrun
);

  localparam logic [7:0]  TO_LAST  = 8'(CS_TIMEOUT - 1);
  localparam logic [15:0] LAST_OFS = IPV4_HDR_LEN - 16'd1;

  state_t      state;
  state_t      next_state;
  logic [3:0]  err_next;
  logic        enter_etype;
  logic        overrun_next;
  logic [7:0]  etype_hi;
  logic [7:0]  cs_cnt;
  logic [15:0] offset;
  logic        rx_start;
  logic        xfer;

  assign offset   = ByteCnt - HDR_BASE;
  assign rx_start = RxStartFrm & RxValid;
  assign xfer     = HdrValid & HdrReady;

  eth_l3_field_cap u_field_cap (
    .clk       (MRxClk),
    .rst_n     (Reset_n),
    .clear     (enter_etype),
    .capture   ((state == ST_HDR) && RxValid),
    .offset    (offset),
    .data      (RxData),
    .protocol  (Protocol),
    .total_len (TotalLen),
    .dst_ip    (DstIp)
  );

  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next state, error accumulation and overrun detection. A frame start
  // anywhere but PRESENT restarts parsing; in PRESENT it is only accepted
  // on the transfer cycle, otherwise it is flagged as an overrun and the
  // rest of that frame is ignored.
  always_comb begin
    next_state   = state;
    err_next     = HdrErr;
    enter_etype  = 1'b0;
    overrun_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_start) begin
          next_state  = ST_ETYPE;
          enter_etype = 1'b1;
        end
      end
      ST_ETYPE: begin
        if (rx_start) begin
          enter_etype = 1'b1;
        end else if (RxEndFrm) begin
          err_next[ERR_NOT_IP]  = 1'b1;
          err_next[ERR_BAD_LEN] = 1'b1;
          next_state            = ST_PRESENT;
        end else if (RxValid && (ByteCnt == HDR_BASE - 16'd1)) begin
          if ({etype_hi, RxData} != ETHTYPE_IPV4) begin
            err_next[ERR_NOT_IP] = 1'b1;
            next_state           = ST_PRESENT;
          end else begin
            next_state = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (rx_start) begin
          next_state  = ST_ETYPE;
          enter_etype = 1'b1;
        end else begin
          if (RxValid && (offset == 16'd0) && (RxData != IPV4_VER_IHL))
            err_next[ERR_BAD_VER_IHL] = 1'b1;
          // The high length byte is already in the capture register.
          if (RxValid && (offset == 16'd3) && ({TotalLen[15:8], RxData} < IPV4_HDR_LEN))
            err_next[ERR_BAD_LEN] = 1'b1;
          if (RxEndFrm) begin
            err_next[ERR_BAD_LEN] = 1'b1;
            next_state            = ST_PRESENT;
          end else if (RxValid && (offset == LAST_OFS)) begin
            next_state = ST_WAIT_CS;
          end
        end
      end
      ST_WAIT_CS: begin
        if (rx_start) begin
          next_state  = ST_ETYPE;
          enter_etype = 1'b1;
        end else if (CSready) begin
          if (CheckSum != 16'h0000) err_next[ERR_BAD_CSUM] = 1'b1;
          next_state = ST_PRESENT;
        end else if (cs_cnt >= TO_LAST) begin
          err_next[ERR_BAD_CSUM] = 1'b1;
          next_state             = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (xfer) begin
          if (rx_start) begin
            next_state  = ST_ETYPE;
            enter_etype = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end else if (rx_start) begin
          overrun_next = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (enter_etype) err_next = 4'b0000;
  end

  // Registered outputs. HdrOk is only asserted alongside a presented
  // verdict so that an idle block never advertises a good header.
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) begin
      HdrErr   <= '0;
      HdrValid <= 1'b0;
      HdrOk    <= 1'b0;
      Overrun  <= 1'b0;
      etype_hi <= '0;
      cs_cnt   <= '0;
    end else begin
      HdrErr   <= err_next;
      HdrValid <= (next_state == ST_PRESENT);
      HdrOk    <= (next_state == ST_PRESENT) && (err_next == 4'b0000);
      Overrun  <= overrun_next;
      if ((state == ST_ETYPE) && RxValid && (ByteCnt == HDR_BASE - 16'd2))
        etype_hi <= RxData;
      if (state == ST_WAIT_CS) begin
        if (cs_cnt != 8'hFF) cs_cnt <= cs_cnt + 8'd1;
      end else begin
        cs_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_l3_hdr_check.sv
// tb_eth_l3_hdr_check
// Directed bench for eth_l3_hdr_check: drives whole frames byte by byte
// and compares the verdict against hand-computed values.
module tb_eth_l3_hdr_check;
  import eth_l3_pkg::*;

  localparam int HDR_BASE = 23;

  logic        MRxClk = 1'b0;
  logic        Reset_n;
  logic [7:0]  RxData;
  logic        RxValid;
  logic [15:0] ByteCnt;
  logic        RxStartFrm;
  logic        RxEndFrm;
  logic [15:0] CheckSum;
  logic        CSready;
  logic        HdrValid;
  logic        HdrReady;
  logic [3:0]  HdrErr;
  logic        HdrOk;
  logic [7:0]  Protocol;
  logic [15:0] TotalLen;
  logic [31:0] DstIp;
  logic        Overrun;

  int checks = 0;
  int errors = 0;

  // 45 00 00 3C | 00 00 00 00 | 40 06 00 00 | C0 A8 01 01 | C0 A8 01 02
  localparam logic [159:0] HDR_GOOD = 160'h4500003C_00000000_40060000_C0A80101_C0A80102;
  // Version/IHL 46 with total length 0x0010
  localparam logic [159:0] HDR_BAD  = 160'h46000010_00000000_40110000_0A000001_0A000002;

  eth_l3_hdr_check #(.HDR_BASE(16'h17), .CS_TIMEOUT(8)) dut (
    .MRxClk     (MRxClk),
    .Reset_n    (Reset_n),
    .RxData     (RxData),
    .RxValid    (RxValid),
    .ByteCnt    (ByteCnt),
    .RxStartFrm (RxStartFrm),
    .RxEndFrm   (RxEndFrm),
    .CheckSum   (CheckSum),
    .CSready    (CSready),
    .HdrValid   (HdrValid),
    .HdrReady   (HdrReady),
    .HdrErr     (HdrErr),
    .HdrOk      (HdrOk),
    .Protocol   (Protocol),
    .TotalLen   (TotalLen),
    .DstIp      (DstIp),
    .Overrun    (Overrun)
  );

  always #5 MRxClk = ~MRxClk;

  // Sends frame bytes first_idx..HDR_BASE+n_hdr-1; byte 0 carries the
  // start marker, the last byte the end marker when eof_last is set.
  task automatic send_frame(input logic [15:0] etype, input logic [159:0] hdr,
                            input int n_hdr, input bit eof_last, input int first_idx);
    int last;
    last = HDR_BASE + n_hdr - 1;
    for (int i = first_idx; i <= last; i++) begin
      RxValid    = 1'b1;
      ByteCnt    = 16'(i);
      RxStartFrm = (i == 0);
      RxEndFrm   = eof_last && (i == last);
      if (i == HDR_BASE - 2)      RxData = etype[15:8];
      else if (i == HDR_BASE - 1) RxData = etype[7:0];
      else if (i >= HDR_BASE)     RxData = hdr[159 - 8*(i - HDR_BASE) -: 8];
      else                        RxData = 8'hA0 ^ 8'(i);
      @(posedge MRxClk); #1;
    end
    RxValid    = 1'b0;
    RxStartFrm = 1'b0;
    RxEndFrm   = 1'b0;
  endtask

  task automatic give_csum(input logic [15:0] cs);
    CheckSum = cs;
    CSready  = 1'b1;
    @(posedge MRxClk); #1;
    CSready  = 1'b0;
  endtask

  task automatic accept();
    HdrReady = 1'b1;
    @(posedge MRxClk); #1;
    HdrReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge MRxClk);
    #1;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", HdrValid); end
    checks++; if (HdrErr !== 4'b0000) begin errors++; $display("[TB] FAIL reset_err got %b exp 0000", HdrErr); end
    checks++; if (HdrOk !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok got %b exp 0", HdrOk); end
    checks++; if (Protocol !== 8'h00) begin errors++; $display("[TB] FAIL reset_proto got %h exp 00", Protocol); end
    checks++; if (TotalLen !== 16'h0000) begin errors++; $display("[TB] FAIL reset_len got %h exp 0000", TotalLen); end
    checks++; if (DstIp !== 32'h0) begin errors++; $display("[TB] FAIL reset_dstip got %h exp 00000000", DstIp); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b exp 0", Overrun); end
    Reset_n = 1'b1;
    @(posedge MRxClk); #1;
  endtask

  task automatic test_valid_ipv4();
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL ip_wait_valid got %b exp 0", HdrValid); end
    give_csum(16'h0000);
    checks++; if (HdrValid !== 1'b1) begin errors++; $display("[TB] FAIL ip_valid got %b exp 1", HdrValid); end
    checks++; if (HdrErr !== 4'b0000) begin errors++; $display("[TB] FAIL ip_err got %b exp 0000", HdrErr); end
    checks++; if (HdrOk !== 1'b1) begin errors++; $display("[TB] FAIL ip_ok got %b exp 1", HdrOk); end
    checks++; if (Protocol !== 8'h06) begin errors++; $display("[TB] FAIL ip_proto got %h exp 06", Protocol); end
    checks++; if (TotalLen !== 16'h003C) begin errors++; $display("[TB] FAIL ip_len got %h exp 003c", TotalLen); end
    checks++; if (DstIp !== 32'hC0A80102) begin errors++; $display("[TB] FAIL ip_dstip got %h exp c0a80102", DstIp); end
    accept();
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL ip_xfer_valid got %b exp 0", HdrValid); end
  endtask

  task automatic test_not_ip();
    send_frame(16'h86DD, HDR_GOOD, 0, 1'b0, 0);
    checks++; if (HdrValid !== 1'b1) begin errors++; $display("[TB] FAIL notip_valid got %b exp 1", HdrValid); end
    checks++; if (HdrErr !== 4'b0001) begin errors++; $display("[TB] FAIL notip_err got %b exp 0001", HdrErr); end
    checks++; if (HdrOk !== 1'b0) begin errors++; $display("[TB] FAIL notip_ok got %b exp 0", HdrOk); end
    checks++; if (DstIp !== 32'h0) begin errors++; $display("[TB] FAIL notip_dstip got %h exp 00000000", DstIp); end
    checks++; if (Protocol !== 8'h00) begin errors++; $display("[TB] FAIL notip_proto got %h exp 00", Protocol); end
    accept();
  endtask

  task automatic test_bad_csum();
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    give_csum(16'h1234);
    checks++; if (HdrErr !== 4'b0100) begin errors++; $display("[TB] FAIL csum_err got %b exp 0100", HdrErr); end
    checks++; if (HdrOk !== 1'b0) begin errors++; $display("[TB] FAIL csum_ok got %b exp 0", HdrOk); end
    accept();
    // Checksum never arrives: verdict on the eighth cycle in WAIT_CS
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    repeat (7) @(posedge MRxClk);
    #1;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b exp 0", HdrValid); end
    @(posedge MRxClk); #1;
    checks++; if (HdrValid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_valid got %b exp 1", HdrValid); end
    checks++; if (HdrErr !== 4'b0100) begin errors++; $display("[TB] FAIL timeout_err got %b exp 0100", HdrErr); end
    checks++; if (DstIp !== 32'hC0A80102) begin errors++; $display("[TB] FAIL timeout_dstip got %h exp c0a80102", DstIp); end
    accept();
  endtask

  task automatic test_bad_ver_len();
    send_frame(ETHTYPE_IPV4, HDR_BAD, 20, 1'b0, 0);
    give_csum(16'h0000);
    checks++; if (HdrErr !== 4'b1010) begin errors++; $display("[TB] FAIL verlen_err got %b exp 1010", HdrErr); end
    checks++; if (TotalLen !== 16'h0010) begin errors++; $display("[TB] FAIL verlen_len got %h exp 0010", TotalLen); end
    checks++; if (Protocol !== 8'h11) begin errors++; $display("[TB] FAIL verlen_proto got %h exp 11", Protocol); end
    accept();
  endtask

  task automatic test_truncation();
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 6, 1'b1, 0);
    checks++; if (HdrValid !== 1'b1) begin errors++; $display("[TB] FAIL trunc_valid got %b exp 1", HdrValid); end
    checks++; if (HdrErr !== 4'b1000) begin errors++; $display("[TB] FAIL trunc_err got %b exp 1000", HdrErr); end
    checks++; if (TotalLen !== 16'h003C) begin errors++; $display("[TB] FAIL trunc_len got %h exp 003c", TotalLen); end
    checks++; if (DstIp !== 32'h0) begin errors++; $display("[TB] FAIL trunc_dstip got %h exp 00000000", DstIp); end
    accept();
  endtask

  task automatic test_overrun();
    int ovr_cnt;
    int unstable;
    ovr_cnt  = 0;
    unstable = 0;
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    give_csum(16'h0000);
    // A whole non-IP frame arrives while the verdict is held.
    for (int c = 0; c < 50; c++) begin
      if (c >= 5 && c < 5 + HDR_BASE) begin
        RxValid    = 1'b1;
        ByteCnt    = 16'(c - 5);
        RxStartFrm = (c == 5);
        RxData     = (c - 5 == HDR_BASE - 2) ? 8'h86 : 8'hDD;
      end else begin
        RxValid    = 1'b0;
        RxStartFrm = 1'b0;
      end
      @(posedge MRxClk); #1;
      if (Overrun === 1'b1) ovr_cnt++;
      if (HdrValid !== 1'b1 || HdrErr !== 4'b0000 || DstIp !== 32'hC0A80102 || HdrOk !== 1'b1)
        unstable++;
    end
    RxValid    = 1'b0;
    RxStartFrm = 1'b0;
    checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL ovr_stable got %0d unstable cycles exp 0", unstable); end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("[TB] FAIL ovr_pulses got %0d exp 1", ovr_cnt); end
    accept();
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_xfer got %b exp 0", HdrValid); end
    repeat (10) @(posedge MRxClk);
    #1;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_second got %b exp 0", HdrValid); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL ovr_idle got %0d exp %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    give_csum(16'h0000);
    // Start of the next frame lands on the transfer cycle.
    HdrReady   = 1'b1;
    RxValid    = 1'b1;
    RxStartFrm = 1'b1;
    ByteCnt    = 16'd0;
    RxData     = 8'h55;
    @(posedge MRxClk); #1;
    HdrReady   = 1'b0;
    RxStartFrm = 1'b0;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_xfer got %b exp 0", HdrValid); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got %b exp 0", Overrun); end
    send_frame(16'h0806, HDR_GOOD, 0, 1'b0, 1);
    checks++; if (HdrValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got %b exp 1", HdrValid); end
    checks++; if (HdrErr !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_err got %b exp 0001", HdrErr); end
    accept();
  endtask

  task automatic test_reset_midframe();
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 11, 1'b0, 0);
    Reset_n = 1'b0;
    #1;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b exp 0", HdrValid); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL rst_mid_state got %0d exp %0d", dut.state, ST_IDLE); end
    checks++; if (TotalLen !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_len got %h exp 0000", TotalLen); end
    @(posedge MRxClk); #1;
    Reset_n = 1'b1;
    repeat (12) @(posedge MRxClk);
    #1;
    checks++; if (HdrValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_noverdict got %b exp 0", HdrValid); end
    send_frame(ETHTYPE_IPV4, HDR_GOOD, 20, 1'b0, 0);
    give_csum(16'h0000);
    checks++; if (HdrOk !== 1'b1) begin errors++; $display("[TB] FAIL rst_next_ok got %b exp 1", HdrOk); end
    checks++; if (DstIp !== 32'hC0A80102) begin errors++; $display("[TB] FAIL rst_next_dstip got %h exp c0a80102", DstIp); end
    accept();
  endtask

  initial begin
    Reset_n    = 1'b0;
    RxData     = 8'h00;
    RxValid    = 1'b0;
    ByteCnt    = 16'h0000;
    RxStartFrm = 1'b0;
    RxEndFrm   = 1'b0;
    CheckSum   = 16'h0000;
    CSready    = 1'b0;
    HdrReady   = 1'b0;
    test_reset();
    test_valid_ipv4();
    test_not_ip();
    test_bad_csum();
    test_bad_ver_len();
    test_truncation();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
